// File: rtl/dot_product_scheduler_if.sv
// dot_product_scheduler_if
//   Bundles the operand-memory read bus and the result channel of the
//   dot-product scheduler.
//   Memory read bus : rd_en, rd_addr (shared by both memories),
//                     rd_data_a, rd_data_b (1-cycle synchronous read data)
//   Result channel  : res_valid/res_ready handshake carrying res_data and
//                     res_index
//   master modport  : scheduler side
//   slave modport   : memories + result consumer side
interface dot_product_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ACC_WIDTH  = 19,
  parameter int IDX_WIDTH  = 2
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic [IDX_WIDTH-1:0]  res_index;

  modport master (
    output rd_en, rd_addr, res_valid, res_data, res_index,
    input  rd_data_a, rd_data_b, res_ready
  );

  modport slave (
    input  rd_en, rd_addr, res_valid, res_data, res_index,
    output rd_data_a, rd_data_b, res_ready
  );
endinterface

// File: rtl/dot_product_scheduler.sv
// dot_product_scheduler
//   Walks both operand memories through one shared read address, multiplies
//   and accumulates VEC_LEN element pairs per vector, and hands each of the
//   NUMBER_OF_VECTORS results to the consumer over a valid/ready channel.
//   A one-cycle done pulse follows the last result transfer.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     start       : begin a run (only looked at while idle)
//     abort       : cancel a run in progress, no done pulse
//     bus         : memory read bus + result channel (master side)
//     busy        : high whenever the engine is not idle
//     done        : one-cycle pulse after the final result transfer
//   All outputs are registered.
module dot_product_scheduler #(
  parameter int DATA_WIDTH        = 8,
  parameter int VEC_LEN           = 8,
  parameter int NUMBER_OF_VECTORS = 4,
  parameter int ADDR_WIDTH        = 5,
  parameter int ACC_WIDTH         = 19,
  parameter int IDX_WIDTH         = (NUMBER_OF_VECTORS > 1) ? $clog2(NUMBER_OF_VECTORS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  dot_product_scheduler_if.master bus,
  output logic                    busy,
  output logic                    done
);

  localparam int ELEM_WIDTH = $clog2(VEC_LEN);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam logic [ELEM_WIDTH-1:0] LAST_ELEM = ELEM_WIDTH'(VEC_LEN - 1);
  localparam logic [IDX_WIDTH-1:0]  LAST_VEC  = IDX_WIDTH'(NUMBER_OF_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ELEM_WIDTH-1:0] element_q, element_d;
  logic [IDX_WIDTH-1:0]  vector_q, vector_d;
  logic                  data_vld_q, data_vld_d;
  logic                  first_q, first_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
  logic [IDX_WIDTH-1:0]  res_index_q, res_index_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [PROD_WIDTH-1:0] product;
  logic [ACC_WIDTH-1:0]  acc_next;

  function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [IDX_WIDTH-1:0]  v,
                                                      input logic [ELEM_WIDTH-1:0] e);
    return ADDR_WIDTH'(int'(v) * VEC_LEN + int'(e));
  endfunction

  // Full-precision unsigned product; the first element of a vector restarts
  // the sum so no separate accumulator clear is needed between vectors.
  assign product  = PROD_WIDTH'(bus.rd_data_a) * PROD_WIDTH'(bus.rd_data_b);
  assign acc_next = (first_q ? '0 : acc_q) + ACC_WIDTH'(product);

  always_comb begin
    state_d     = state_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    element_d   = element_q;
    vector_d    = vector_q;
    // Memory data shows up one cycle after a sampled read, so the valid and
    // first-element flags are simply the read request delayed by one cycle.
    data_vld_d  = rd_en_q;
    first_d     = rd_en_q && (element_q == '0);
    acc_d       = data_vld_q ? acc_next : acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;
    done_d      = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      rd_en_d     = 1'b0;
      res_valid_d = 1'b0;
      acc_d       = '0;
      data_vld_d  = 1'b0;
      first_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = FETCH;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            element_d = '0;
            vector_d  = '0;
          end
        end
        FETCH: begin
          // The last element's address is on the bus this cycle; the edge
          // closing it is the one the memory samples it on.
          if (element_q == LAST_ELEM) begin
            state_d = DRAIN;
            rd_en_d = 1'b0;
          end else begin
            element_d = element_q + 1'b1;
            rd_addr_d = elem_addr(vector_q, element_d);
          end
        end
        DRAIN: begin
          state_d     = OUTPUT;
          res_valid_d = 1'b1;
          res_data_d  = acc_d;
          res_index_d = vector_q;
        end
        OUTPUT: begin
          // Nothing is fetched while a result waits, so backpressure stalls
          // the whole engine and the next fetch starts on the transfer edge.
          if (bus.res_ready) begin
            res_valid_d = 1'b0;
            if (vector_q != LAST_VEC) begin
              vector_d  = vector_q + 1'b1;
              element_d = '0;
              state_d   = FETCH;
              rd_en_d   = 1'b1;
              rd_addr_d = elem_addr(vector_d, '0);
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      element_q   <= '0;
      vector_q    <= '0;
      data_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      element_q   <= element_d;
      vector_q    <= vector_d;
      data_vld_q  <= data_vld_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_index = res_index_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// tb_dot_product_scheduler
//   Drives the scheduler with 1-cycle synchronous operand memories and a
//   result consumer, and compares results against a dot-product model
//   computed directly from the memory contents.
module tb_dot_product_scheduler;
  localparam int DW    = 8;
  localparam int VL    = 8;
  localparam int NV    = 4;
  localparam int AW    = 5;
  localparam int ACCW  = 19;
  localparam int IW    = 2;
  localparam int DEPTH = VL * NV;

  logic clk, rst_n, start, abort, busy, done;

  dot_product_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .IDX_WIDTH(IW)) bus_if ();

  dot_product_scheduler #(
    .DATA_WIDTH(DW), .VEC_LEN(VL), .NUMBER_OF_VECTORS(NV),
    .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bus(bus_if), .busy(busy), .done(done)
  );

  logic [DW-1:0] mem_a [0:DEPTH-1];
  logic [DW-1:0] mem_b [0:DEPTH-1];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  int got_data[$];
  int got_idx[$];
  int got_addr[$];
  int done_cnt, first_lat, timed_out, results_at_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories: data for a sampled read appears after that edge.
  always @(posedge clk) begin
    if (bus_if.rd_en) begin
      bus_if.rd_data_a <= mem_a[bus_if.rd_addr];
      bus_if.rd_data_b <= mem_b[bus_if.rd_addr];
    end
  end

  // Reference model: plain sum of element-wise products of one vector.
  function automatic int expected_dot(input int v);
    int sum = 0;
    for (int i = 0; i < VL; i++)
      sum += int'(mem_a[v*VL+i]) * int'(mem_b[v*VL+i]);
    return sum;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(1);
    end
  endtask

  task automatic fill_const(input int val);
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'(val);
      mem_b[i] = DW'(val);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'($urandom_range(0, 255));
      mem_b[i] = DW'($urandom_range(0, 255));
    end
  endtask

  // Runs the engine and records transfers, addresses and done pulses.
  // ready_mode 0: always ready, 1: random. inject_at: loop cycle with a
  // stray start pulse (-1 none). start_on_done: raise start in the done
  // cycle and return immediately.
  task automatic collect_run(input bit do_start, input int ready_mode,
                             input int inject_at, input bit start_on_done);
    int s;
    int post = 0;
    got_data.delete();
    got_idx.delete();
    got_addr.delete();
    done_cnt = 0;
    first_lat = -1;
    timed_out = 0;
    results_at_done = -1;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    s = cyc;
    for (int k = 0; k < 400; k++) begin
      bus_if.res_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      start = (k == inject_at);
      if (bus_if.rd_en) got_addr.push_back(int'(bus_if.rd_addr));
      if (bus_if.res_valid && first_lat < 0) first_lat = cyc - s;
      if (bus_if.res_valid && bus_if.res_ready) begin
        got_data.push_back(int'(bus_if.res_data));
        got_idx.push_back(int'(bus_if.res_index));
      end
      if (done) begin
        done_cnt++;
        if (results_at_done < 0) results_at_done = got_data.size();
        if (start_on_done) begin
          start = 1'b1;
          return;
        end
      end
      if (done_cnt > 0) post++;
      if (post == 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    bus_if.res_ready = 1'b1;
    if (done_cnt == 0) timed_out = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus_if.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_if.rd_en, bus_if.rd_addr, bus_if.res_valid, bus_if.res_data, bus_if.res_index, busy, done} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {bus_if.rd_en, bus_if.rd_addr, bus_if.res_valid, bus_if.res_data, bus_if.res_index, busy, done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus_if.rd_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b rd_en=%b required 0 0", busy, bus_if.rd_en);
    end
  endtask

  task automatic test_basic();
    int exp_vals[NV] = '{36, 100, 164, 228};
    fill_ramp();
    collect_run(1'b1, 0, -1, 1'b0);
    checks++;
    if (timed_out != 0 || got_data.size() != NV) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d results (timeout=%0d) required %0d", got_data.size(), timed_out, NV);
    end else begin
      for (int v = 0; v < NV; v++) begin
        checks++;
        if (got_data[v] !== exp_vals[v] || got_idx[v] !== v) begin
          errors++;
          $display("[TB] FAIL basic_result[%0d]: got %0d idx %0d required %0d idx %0d", v, got_data[v], got_idx[v], exp_vals[v], v);
        end
      end
    end
    // Reads are sampled on edges 1..VL after start, the last product arrives
    // after edge VL and is summed and registered on the following edge.
    checks++;
    if (first_lat !== VL + 1) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d edges required %0d", first_lat, VL + 1);
    end
    checks++;
    if (done_cnt !== 1 || results_at_done !== NV) begin
      errors++;
      $display("[TB] FAIL basic_done: got %0d pulses after %0d results required 1 after %0d", done_cnt, results_at_done, NV);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy_end: got %b required 0", busy);
    end
    checks++;
    if (got_addr.size() != DEPTH) begin
      errors++;
      $display("[TB] FAIL basic_addr_count: got %0d required %0d", got_addr.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (got_addr[i] !== i) begin
          errors++;
          $display("[TB] FAIL basic_addr[%0d]: got %0d required %0d", i, got_addr[i], i);
          break;
        end
      end
    end
  endtask

  task automatic test_overflow();
    fill_const(255);
    collect_run(1'b1, 0, -1, 1'b0);
    checks++;
    if (got_data.size() != NV) begin
      errors++;
      $display("[TB] FAIL overflow_count: got %0d required %0d", got_data.size(), NV);
    end else begin
      for (int v = 0; v < NV; v++) begin
        checks++;
        if (got_data[v] !== 520200) begin
          errors++;
          $display("[TB] FAIL overflow_result[%0d]: got %0d required 520200", v, got_data[v]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      fill_random();
      collect_run(1'b1, 1, -1, 1'b0);
      checks++;
      if (got_data.size() != NV || done_cnt !== 1) begin
        errors++;
        $display("[TB] FAIL random_count[%0d]: got %0d results %0d done required %0d 1", it, got_data.size(), done_cnt, NV);
      end else begin
        for (int v = 0; v < NV; v++) begin
          checks++;
          if (got_data[v] !== expected_dot(v) || got_idx[v] !== v) begin
            errors++;
            $display("[TB] FAIL random_result[%0d][%0d]: got %0d idx %0d required %0d idx %0d",
                     it, v, got_data[v], got_idx[v], expected_dot(v), v);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int stall = 0;
    int done_seen = 0;
    bit fetch_pending = 0;
    fill_ramp();
    got_data.delete();
    @(negedge clk);
    start = 1'b1;
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (fetch_pending) begin
        fetch_pending = 0;
        checks++;
        if (bus_if.rd_en !== 1'b1 || int'(bus_if.rd_addr) !== 2 * VL) begin
          errors++;
          $display("[TB] FAIL bp_fetch_resume: rd_en=%b addr=%0d required 1 %0d", bus_if.rd_en, bus_if.rd_addr, 2 * VL);
        end
      end
      if (bus_if.res_valid && bus_if.res_index == 2'd1 && stall < 5) begin
        bus_if.res_ready = 1'b0;
        stall++;
        checks++;
        if (bus_if.res_data !== 19'd100 || bus_if.rd_en !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_stall[%0d]: data=%0d rd_en=%b required 100 0", stall, bus_if.res_data, bus_if.rd_en);
        end
      end else begin
        bus_if.res_ready = 1'b1;
      end
      if (bus_if.res_valid && bus_if.res_ready) begin
        got_data.push_back(int'(bus_if.res_data));
        if (bus_if.res_index == 2'd1) fetch_pending = 1;
      end
      if (done) begin
        done_seen++;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (stall !== 5 || done_seen !== 1) begin
      errors++;
      $display("[TB] FAIL bp_progress: stall=%0d done=%0d required 5 1", stall, done_seen);
    end
    checks++;
    if (got_data.size() != NV || got_data[0] !== 36 || got_data[1] !== 100 || got_data[2] !== 164 || got_data[3] !== 228) begin
      errors++;
      $display("[TB] FAIL bp_results: got %p required 36 100 164 228", got_data);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int xfers = 0;
    int done_seen = 0;
    int rd_seen = 0;
    bit hit = 0;
    fill_ramp();
    @(negedge clk);
    start = 1'b1;
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (bus_if.res_valid && bus_if.res_ready) xfers++;
      if (bus_if.rd_en && int'(bus_if.rd_addr) == 2 * VL + 3) begin
        abort = 1'b1;
        hit = 1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if (!hit || xfers !== 2) begin
      errors++;
      $display("[TB] FAIL abort_reach: hit=%0d transfers=%0d required 1 2", hit, xfers);
    end
    checks++;
    if (busy !== 1'b0 || bus_if.rd_en !== 1'b0 || bus_if.res_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: busy=%b rd_en=%b res_valid=%b done=%b required 0 0 0 0",
               busy, bus_if.rd_en, bus_if.res_valid, done);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (bus_if.rd_en) rd_seen++;
    end
    checks++;
    if (done_seen !== 0 || rd_seen !== 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: done=%0d rd_en=%0d cycles required 0 0", done_seen, rd_seen);
    end
    collect_run(1'b1, 0, -1, 1'b0);
    checks++;
    if (got_data.size() != NV || got_data[0] !== 36 || got_data[3] !== 228) begin
      errors++;
      $display("[TB] FAIL abort_rerun: got %p required 36 100 164 228", got_data);
    end
  endtask

  task automatic test_start_while_busy();
    bit addr_ok = 1;
    fill_ramp();
    collect_run(1'b1, 0, 12, 1'b0);
    for (int i = 0; i < got_addr.size(); i++)
      if (got_addr[i] !== i) addr_ok = 0;
    checks++;
    if (got_data.size() != NV || done_cnt !== 1 || got_addr.size() != DEPTH || !addr_ok) begin
      errors++;
      $display("[TB] FAIL busy_start_ignored: results=%0d done=%0d addrs=%0d in_order=%0d required %0d 1 %0d 1",
               got_data.size(), done_cnt, got_addr.size(), addr_ok, NV, DEPTH);
    end
    collect_run(1'b1, 0, -1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bus_if.rd_en !== 1'b1 || bus_if.rd_addr !== '0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_cycle_start: rd_en=%b addr=%0d busy=%b required 1 0 1", bus_if.rd_en, bus_if.rd_addr, busy);
    end
    collect_run(1'b0, 0, -1, 1'b0);
    checks++;
    if (got_data.size() != NV || got_data[0] !== 36 || got_addr.size() != DEPTH || got_addr[0] !== 0) begin
      errors++;
      $display("[TB] FAIL done_cycle_run: results=%0d addrs=%0d required %0d %0d", got_data.size(), got_addr.size(), NV, DEPTH);
    end
  endtask

  task automatic test_reset_mid_output();
    bit seen = 0;
    fill_ramp();
    bus_if.res_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (bus_if.res_valid) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL rst_mid_reach: res_valid never rose within 50 cycles");
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.rd_en, bus_if.rd_addr, bus_if.res_valid, bus_if.res_data, bus_if.res_index, busy, done} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: got %h required 0",
               {bus_if.rd_en, bus_if.rd_addr, bus_if.res_valid, bus_if.res_data, bus_if.res_index, busy, done});
    end
    rst_n = 1'b1;
    bus_if.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    collect_run(1'b1, 0, -1, 1'b0);
    checks++;
    if (got_data.size() != NV || got_data[0] !== 36 || got_idx[0] !== 0) begin
      errors++;
      $display("[TB] FAIL rst_mid_rerun: results=%0d first=%0d required %0d 36", got_data.size(),
               (got_data.size() > 0) ? got_data[0] : -1, NV);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_reset_mid_output();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
